cp0_irq_unit: RTL and testbench
===============================

Name: cp0_irq_unit

Overview:
- Parametrised CP0 exception/interrupt unit for the 5-stage pipelined CPU. Successor to the fixed 1-irq, 4-cause control logic.
- Adds:
  - NIRQ interrupt lines, each configurable as level- or edge-sensitive, with a pending register and per-line mask.
  - Fixed-priority selection, optional vectored dispatch.
  - A DEPTH-level interrupt-enable stack for nesting, plus a nesting counter and double-fault detection.
- Owns the Status, Cause and EPC registers. Supplies the redirect request and vector address to the IF-stage PC mux.

Parameters:
- NIRQ, 4: number of interrupt lines, 1..8.
- EDGE, 0 (NIRQ bits): bit n = 1 makes irq[n] rising-edge-sensitive; bit n = 0 makes it level-sensitive.
- DEPTH, 3: IE stack / nesting depth, 1..4.
- BASE, 32'h00000008: exception base address.
- VEC_MODE, 0: 0 sends all events to BASE; 1 sends interrupt n to BASE+32'h200+32*n.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  synchronous active-low reset.
- irq  in  NIRQ  interrupt requests, already synchronised to clk.
- exc_req  in  1  synchronous exception present in ID (syscall/unimpl/ovf), decoded by the control unit.
- exc_code  in  5  ExcCode for exc_req (8 sys, 10 unimpl, 12 ovf).
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a delay slot.
- int_pc  in  32  PC to resume at if an interrupt is taken this cycle.
- int_bd  in  1  int_pc is a delay-slot instruction.
- take_ok  in  1  pipeline can accept a redirect this cycle (not stalled).
- eret  in  1  eret in ID, qualified by the control unit.
- mtc0  in  1  mtc0 in ID.
- rd  in  5  CP0 register number for mtc0/mfc0.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 read data, combinational.
- exc  out  1  take exception/interrupt now, combinational.
- exc_vec  out  32  redirect target when exc = 1.
- inta  out  NIRQ  one-hot acknowledge, same cycle as an interrupt take.
- sta  out  32  Status register.
- cause  out  32  Cause register.
- epc  out  32  EPC register, used as the eret target.
- depth  out  3  current nesting level, 0..DEPTH.
- dbl_fault  out  1  sticky double-fault flag.

Behaviour:
- Reset (clrn = 0 at a clk edge): sta, cause, epc, pend, irq_q, depth and dbl_fault all clear to 0. Combinational outputs follow from the cleared state.
- Status layout:
  - sta[DEPTH-1:0] is the IE stack; sta[0] is the current IE.
  - sta[8+:NIRQ] is IM.
  - All other bits read 0.
- Cause layout:
  - cause[31] is BD.
  - cause[8+:NIRQ] is IP (= pend).
  - cause[6:2] is ExcCode.
  - All other bits read 0.
- Pending register:
  - irq_q registers irq every cycle.
  - Level line n: pend[n] <= irq[n].
  - Edge line n:
    - Set on irq[n] & ~irq_q[n].
    - Cleared when inta[n] = 1, or on mtc0 to rd 13 with wdata[8+n] = 1 (write-1-to-clear).
    - Set wins over a same-cycle clear.
- Interrupt candidate:
  - act = pend & IM.
  - Selected line = lowest index set in act.
  - int_take = sta[0] & |act & take_ok & ~exc_req.
- Synchronous exception take: sync_take = exc_req & take_ok. If take_ok = 0, nothing happens; the pipeline re-presents the request.
- exc = sync_take | int_take. A synchronous exception always has priority over an interrupt; the interrupt stays pending.
- On take (clock edge with exc = 1):
  - epc <= bd ? pc-4 : pc, using the exc or int pair as appropriate; 32-bit wrap.
  - cause[31] <= bd.
  - ExcCode <= exc_code for an exception, 0 for an interrupt.
  - IE stack <= {stack[DEPTH-2:0], 0}.
  - depth <= depth+1, saturating at DEPTH.
- Double fault:
  - Occurs when a take happens with depth == DEPTH.
  - dbl_fault <= 1 (sticky until reset).
  - exc_vec = BASE+32'h100 for that take.
  - depth stays at DEPTH; the stack and EPC still update.
- exc_vec:
  - Double fault: BASE+32'h100.
  - Interrupt with VEC_MODE = 1: BASE+32'h200+(idx<<5).
  - Otherwise: BASE.
- inta: one-hot at the selected index when int_take = 1, otherwise 0.
- eret (with exc = 0):
  - IE stack <= {0, stack[DEPTH-1:1]}.
  - depth <= depth-1, floor 0.
  - eret in the same cycle as exc is ignored.
- mtc0 (with exc = 0):
  - rd 12: writes IE stack bits and IM only.
  - rd 13: W1C on edge-line IP bits only.
  - rd 14: writes all of epc.
  - Other rd values: no effect.
  - mtc0 in the same cycle as exc is dropped. mtc0 to rd 12 in the same cycle as eret: the mtc0 write wins.
- mfc0: rdata = sta (rd 12), cause (rd 13), epc (rd 14), else 0.
- Reset mid-operation: all state clears in that cycle; pending edges are lost.

Test Plan:
- Reset, then mtc0 rd12 = 32'h00000F01; raise irq = 4'b0110 (level) -> exc = 1, inta = 4'b0010, vector 32'h00000008; next cycle ExcCode = 0, sta[0] = 0, depth = 1, epc = int_pc.
- VEC_MODE = 1, EDGE = 4'b1000: pulse irq[3] for one cycle with IE = 0 -> pend[3] stays 1; set IE = 1 -> exc_vec = 32'h00000268; pend[3] clears after inta. Separately, pend[3] set then W1C via mtc0 rd13 = 32'h800 -> IP3 = 0.
- exc_req (code 8) and irq active in the same cycle -> exception taken, ExcCode = 8, inta = 0; interrupt taken later after IE is restored.
- exc_bd = 1, exc_pc = 32'h00000104 -> epc = 32'h00000100, cause[31] = 1; eret -> IE restored from stack, depth decremented.
- DEPTH = 3: four nested takes without eret -> fourth take vectors to 32'h00000108, dbl_fault = 1, depth = 3; dbl_fault persists until clrn = 0.
- take_ok = 0 with a pending interrupt -> exc = 0 and no state change; mtc0 with exc = 1 -> write dropped.

Source files
------------

// File: rtl/cp0_irq_unit_if.sv
// CP0 interrupt/exception unit bus: pipeline-side requests in,
// redirect, acknowledge and CP0 register views out.
interface cp0_irq_unit_if #(
    parameter int unsigned NIRQ = 4
);
    logic [NIRQ-1:0] irq;
    logic            exc_req;
    logic [4:0]      exc_code;
    logic [31:0]     exc_pc;
    logic            exc_bd;
    logic [31:0]     int_pc;
    logic            int_bd;
    logic            take_ok;
    logic            eret;
    logic            mtc0;
    logic [4:0]      rd;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            exc;
    logic [31:0]     exc_vec;
    logic [NIRQ-1:0] inta;
    logic [31:0]     sta;
    logic [31:0]     cause;
    logic [31:0]     epc;
    logic [2:0]      depth;
    logic            dbl_fault;

    modport master (
        output irq, exc_req, exc_code, exc_pc, exc_bd,
        output int_pc, int_bd, take_ok, eret, mtc0, rd, wdata,
        input  rdata, exc, exc_vec, inta, sta, cause, epc,
        input  depth, dbl_fault
    );

    modport slave (
        input  irq, exc_req, exc_code, exc_pc, exc_bd,
        input  int_pc, int_bd, take_ok, eret, mtc0, rd, wdata,
        output rdata, exc, exc_vec, inta, sta, cause, epc,
        output depth, dbl_fault
    );
endinterface

// File: rtl/cp0_irq_unit.sv
// CP0 exception/interrupt unit: pending/mask, priority select,
// IE stack for nesting, EPC/Cause/Status and double-fault tracking.
module cp0_irq_unit #(
    parameter int unsigned NIRQ     = 4,
    parameter int unsigned EDGE     = 0,
    parameter int unsigned DEPTH    = 3,
    parameter logic [31:0] BASE     = 32'h00000008,
    parameter bit          VEC_MODE = 1'b0
) (
    input logic            clk,
    input logic            clrn,
    cp0_irq_unit_if.slave  bus
);
    localparam logic [NIRQ-1:0] EM = NIRQ'(EDGE);

    logic [DEPTH-1:0] ie_q, ie_d;
    logic [NIRQ-1:0]  im_q, im_d;
    logic [NIRQ-1:0]  pend_q, pend_d;
    logic [NIRQ-1:0]  irq_q;
    logic             bd_q, bd_d;
    logic [4:0]       code_q, code_d;
    logic [31:0]      epc_q, epc_d;
    logic [2:0]       dep_q, dep_d;
    logic             dbl_q, dbl_d;

    logic [NIRQ-1:0]  act, clr, inta;
    logic [2:0]       idx;
    logic             sync_take, int_take, take, at_max, w1c;
    logic [31:0]      tpc, sta, cause;
    logic             tbd;

    always_comb begin
        act = pend_q & im_q;
        idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (act[i]) idx = 3'(i);
        end
        at_max    = (dep_q == 3'(DEPTH));
        sync_take = bus.exc_req & bus.take_ok;
        int_take  = ie_q[0] & (|act) & bus.take_ok & ~bus.exc_req;
        take      = sync_take | int_take;
        inta      = int_take ? (NIRQ'(1) << idx) : '0;
        w1c       = bus.mtc0 & ~take & (bus.rd == 5'd13);
        clr       = inta | (w1c ? bus.wdata[8+:NIRQ] : '0);
    end

    // Edge lines: a new rising edge beats a same-cycle ack or W1C.
    always_comb begin
        pend_d = (EM & ((bus.irq & ~irq_q) | (pend_q & ~clr)))
               | (~EM & bus.irq);
        ie_d   = ie_q;
        im_d   = im_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        dep_d  = dep_q;
        dbl_d  = dbl_q;
        tpc    = sync_take ? bus.exc_pc : bus.int_pc;
        tbd    = sync_take ? bus.exc_bd : bus.int_bd;
        if (take) begin
            epc_d  = tbd ? tpc - 32'd4 : tpc;
            bd_d   = tbd;
            code_d = sync_take ? bus.exc_code : 5'd0;
            ie_d   = ie_q << 1;
            if (at_max) dbl_d = 1'b1;
            else        dep_d = dep_q + 3'd1;
        end else begin
            if (bus.eret) begin
                ie_d = ie_q >> 1;
                if (dep_q != 3'd0) dep_d = dep_q - 3'd1;
            end
            if (bus.mtc0) begin
                unique case (1'b1)
                    (bus.rd == 5'd12): begin
                        ie_d = bus.wdata[DEPTH-1:0];
                        im_d = bus.wdata[8+:NIRQ];
                    end
                    (bus.rd == 5'd14): epc_d = bus.wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ie_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            irq_q  <= '0;
            bd_q   <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
            dep_q  <= '0;
            dbl_q  <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            im_q   <= im_d;
            pend_q <= pend_d;
            irq_q  <= bus.irq;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            dep_q  <= dep_d;
            dbl_q  <= dbl_d;
        end
    end

    always_comb begin
        sta              = '0;
        sta[DEPTH-1:0]   = ie_q;
        sta[8+:NIRQ]     = im_q;
        cause            = '0;
        cause[31]        = bd_q;
        cause[8+:NIRQ]   = pend_q;
        cause[6:2]       = code_q;
        if (take && at_max)
            bus.exc_vec = BASE + 32'h100;
        else if (int_take && VEC_MODE)
            bus.exc_vec = BASE + 32'h200 + {24'b0, idx, 5'b0};
        else
            bus.exc_vec = BASE;
        case (bus.rd)
            5'd12:   bus.rdata = sta;
            5'd13:   bus.rdata = cause;
            5'd14:   bus.rdata = epc_q;
            default: bus.rdata = '0;
        endcase
    end

    assign bus.exc       = take;
    assign bus.inta      = inta;
    assign bus.sta       = sta;
    assign bus.cause     = cause;
    assign bus.epc       = epc_q;
    assign bus.depth     = dep_q;
    assign bus.dbl_fault = dbl_q;
endmodule

// File: tb/tb_cp0_irq_unit.sv
// Directed vector bench for cp0_irq_unit (NIRQ=4, EDGE=4'b1000,
// DEPTH=3, VEC_MODE=1, BASE=8).
module tb_cp0_irq_unit;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    cp0_irq_unit_if #(.NIRQ(4)) bus ();

    cp0_irq_unit #(
        .NIRQ(4), .EDGE(8), .DEPTH(3),
        .BASE(32'h00000008), .VEC_MODE(1'b1)
    ) dut (
        .clk(clk), .clrn(clrn), .bus(bus)
    );

    typedef struct {
        logic [3:0]  irq;
        logic        er;
        logic [4:0]  code;
        logic [31:0] epci;
        logic        ebd;
        logic [31:0] ipc;
        logic        ibd;
        logic        tok;
        logic        eret;
        logic        mtc0;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        xexc;
        logic [31:0] xvec;
        logic [3:0]  xinta;
        logic [31:0] xsta;
        logic [31:0] xcause;
        logic [31:0] xepc;
        logic [2:0]  xdep;
        logic        xdbl;
    } vec_t;

    vec_t tv [29];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int t,
                       input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, t, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.irq      = v.irq;
        bus.exc_req  = v.er;
        bus.exc_code = v.code;
        bus.exc_pc   = v.epci;
        bus.exc_bd   = v.ebd;
        bus.int_pc   = v.ipc;
        bus.int_bd   = v.ibd;
        bus.take_ok  = v.tok;
        bus.eret     = v.eret;
        bus.mtc0     = v.mtc0;
        bus.rd       = v.rd;
        bus.wdata    = v.wd;
    endtask

    task automatic idle(input logic [3:0] irq);
        vec_t v;
        v = '{irq, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0};
        drive(v);
    endtask

    function automatic logic [31:0] xrd(input vec_t v);
        case (v.rd)
            5'd12:   return v.xsta;
            5'd13:   return v.xcause;
            5'd14:   return v.xepc;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        //        irq  er cd epci   ebd ipc  ibd tok ert mt rd  wd            exc vec  inta  sta     cause         epc    dp db
        tv[0]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 0, 0,  0,            0, 8,     4'h0, 0,      0,            0,     0, 0};
        tv[1]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 1, 12, 'hF01,        0, 8,     4'h0, 0,      0,            0,     0, 0};
        tv[2]  = '{4'h6,0,0, 0,      0, 0,    0, 1, 0, 0, 12, 0,            0, 8,     4'h0, 'hF01,  0,            0,     0, 0};
        tv[3]  = '{4'h6,0,0, 0,      0, 'h40, 0, 1, 0, 0, 13, 0,            1, 'h228, 4'h2, 'hF01,  'h600,        0,     0, 0};
        tv[4]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 0, 14, 0,            0, 8,     4'h0, 'hF02,  'h600,        'h40,  1, 0};
        tv[5]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 0, 0,  0,            0, 8,     4'h0, 'hF02,  0,            'h40,  1, 0};
        tv[6]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 1, 12, 'hF00,        0, 8,     4'h0, 'hF01,  0,            'h40,  0, 0};
        tv[7]  = '{4'h8,0,0, 0,      0, 0,    0, 1, 0, 0, 12, 0,            0, 8,     4'h0, 'hF00,  0,            'h40,  0, 0};
        tv[8]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 0, 13, 0,            0, 8,     4'h0, 'hF00,  'h800,        'h40,  0, 0};
        tv[9]  = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 1, 12, 'hF01,        0, 8,     4'h0, 'hF00,  'h800,        'h40,  0, 0};
        tv[10] = '{4'h0,0,0, 0,      0, 'h80, 1, 1, 0, 0, 13, 0,            1, 'h268, 4'h8, 'hF01,  'h800,        'h40,  0, 0};
        tv[11] = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 0, 14, 0,            0, 8,     4'h0, 'hF02,  'h80000000,   'h7C,  1, 0};
        tv[12] = '{4'h8,0,0, 0,      0, 0,    0, 1, 0, 0, 12, 0,            0, 8,     4'h0, 'hF01,  'h80000000,   'h7C,  0, 0};
        tv[13] = '{4'h8,0,0, 0,      0, 'h90, 0, 0, 0, 0, 13, 0,            0, 8,     4'h0, 'hF01,  'h80000800,   'h7C,  0, 0};
        tv[14] = '{4'h0,0,0, 0,      0, 0,    0, 0, 0, 1, 13, 'h800,        0, 8,     4'h0, 'hF01,  'h80000800,   'h7C,  0, 0};
        tv[15] = '{4'h1,0,0, 0,      0, 0,    0, 1, 0, 0, 13, 0,            0, 8,     4'h0, 'hF01,  'h80000000,   'h7C,  0, 0};
        tv[16] = '{4'h1,1,8, 'h104,  1, 'h200,0, 1, 0, 1, 14, 'hDEAD,       1, 8,     4'h0, 'hF01,  'h80000100,   'h7C,  0, 0};
        tv[17] = '{4'h1,0,0, 0,      0, 0,    0, 1, 1, 0, 14, 0,            0, 8,     4'h0, 'hF02,  'h80000120,   'h100, 1, 0};
        tv[18] = '{4'h1,0,0, 0,      0, 'h300,0, 1, 0, 0, 13, 0,            1, 'h208, 4'h1, 'hF01,  'h80000120,   'h100, 0, 0};
        tv[19] = '{4'h0,1,12,'h10,   0, 0,    0, 1, 0, 0, 0,  0,            1, 8,     4'h0, 'hF02,  'h100,        'h300, 1, 0};
        tv[20] = '{4'h0,1,10,'h20,   0, 0,    0, 1, 0, 0, 0,  0,            1, 8,     4'h0, 'hF04,  'h30,         'h10,  2, 0};
        tv[21] = '{4'h0,1,8, 'h30,   0, 0,    0, 1, 0, 0, 0,  0,            1, 'h108, 4'h0, 'hF00,  'h28,         'h20,  3, 0};
        tv[22] = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 0, 14, 0,            0, 8,     4'h0, 'hF00,  'h20,         'h30,  3, 1};
        tv[23] = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 0, 0,  0,            0, 8,     4'h0, 'hF00,  'h20,         'h30,  2, 1};
        tv[24] = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 0, 0,  0,            0, 8,     4'h0, 'hF00,  'h20,         'h30,  1, 1};
        tv[25] = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 0, 0,  0,            0, 8,     4'h0, 'hF00,  'h20,         'h30,  0, 1};
        tv[26] = '{4'h0,0,0, 0,      0, 0,    0, 1, 1, 1, 12, 'hF05,        0, 8,     4'h0, 'hF00,  'h20,         'h30,  0, 1};
        tv[27] = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 1, 15, 'hFFFFFFFF,   0, 8,     4'h0, 'hF05,  'h20,         'h30,  0, 1};
        tv[28] = '{4'h0,0,0, 0,      0, 0,    0, 1, 0, 0, 15, 0,            0, 8,     4'h0, 'hF05,  'h20,         'h30,  0, 1};

        idle(4'h0);
        repeat (2) @(posedge clk);

        for (int t = 0; t < 29; t++) begin
            @(negedge clk);
            clrn = 1'b1;
            drive(tv[t]);
            #1;
            chk("exc",     t, 32'(bus.exc),       32'(tv[t].xexc));
            chk("exc_vec", t, bus.exc_vec,        tv[t].xvec);
            chk("inta",    t, 32'(bus.inta),      32'(tv[t].xinta));
            chk("sta",     t, bus.sta,            tv[t].xsta);
            chk("cause",   t, bus.cause,          tv[t].xcause);
            chk("epc",     t, bus.epc,            tv[t].xepc);
            chk("depth",   t, 32'(bus.depth),     32'(tv[t].xdep));
            chk("dbl",     t, 32'(bus.dbl_fault), 32'(tv[t].xdbl));
            chk("rdata",   t, bus.rdata,          xrd(tv[t]));
        end

        // Edge pending, then reset in the middle: everything clears.
        @(negedge clk);
        idle(4'h8);
        @(negedge clk);
        #1;
        chk("pre_rst_cause", 100, bus.cause, 32'h00000820);
        chk("pre_rst_dbl",   100, 32'(bus.dbl_fault), 32'h1);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("rst_sta",   101, bus.sta,              32'h0);
        chk("rst_cause", 101, bus.cause,            32'h0);
        chk("rst_epc",   101, bus.epc,              32'h0);
        chk("rst_depth", 101, 32'(bus.depth),       32'h0);
        chk("rst_dbl",   101, 32'(bus.dbl_fault),   32'h0);
        chk("rst_exc",   101, 32'(bus.exc),         32'h0);
        chk("rst_inta",  101, 32'(bus.inta),        32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
